// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: serialises IF fetches and MEM data accesses onto one single-port SRAM and
// returns sticky, registered done flags to the pipeline stall logic.
module sram_mem_ctrl #(
    parameter int ACCESS_CYCLES = 3,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_read_done_o,
    input  logic              mem_op_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic              sram_data_oe_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);
    localparam int CW = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              inst_done_q, inst_done_d;
    logic              mem_done_q, mem_done_d;
    logic              busy, last, rd, wr;

    assign busy = (state_q == DATA) || (state_q == INST);
    assign last = cnt_q == LAST;
    assign rd   = (state_q == INST) || (state_q == DATA && !we_q);
    assign wr   = state_q == DATA && we_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        inst_d      = inst_q;
        rdata_d     = rdata_q;
        inst_done_d = inst_done_q;
        mem_done_d  = mem_done_q;
        case (state_q)
            IDLE: begin
                if (!hold_i) begin
                    inst_done_d = 1'b0;
                    mem_done_d  = 1'b0;
                end else if (mem_op_i && !mem_done_q) begin
                    // Data first: it belongs to the older instruction.
                    state_d = DATA;
                    cnt_d   = '0;
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                end else if (!inst_done_q) begin
                    state_d = INST;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                end
            end
            DATA, INST: begin
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state_q == INST) begin
                        inst_done_d = 1'b1;
                        inst_d      = sram_rdata_i;
                    end else begin
                        mem_done_d = 1'b1;
                        rdata_d    = we_q ? rdata_q : sram_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            inst_q      <= '0;
            rdata_q     <= '0;
            inst_done_q <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            inst_q      <= inst_d;
            rdata_q     <= rdata_d;
            inst_done_q <= inst_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // Write strobe leaves one setup cycle before and one hold cycle after.
    assign sram_ce_n_o      = !busy;
    assign sram_oe_n_o      = !rd;
    assign sram_data_oe_o   = wr;
    assign sram_we_n_o      = !(wr && cnt_q != '0 && !last);
    assign sram_addr_o      = addr_q;
    assign sram_wdata_o     = wdata_q;
    assign inst_o           = inst_q;
    assign mem_rdata_o      = rdata_q;
    assign inst_read_done_o = inst_done_q;
    assign mem_done_o       = mem_done_q;
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Single-port SRAM controller directly upstream of the pipeline stall logic.
- Serialises instruction fetch (IF stage) and data access (MEM stage) onto one external SRAM.
- Produces the registered handshake flags `inst_read_done` and `mem_done` that the stall logic combines into `hold`.
- Consumes `hold` back to learn when the pipeline advances; flags are registered, so there is no combinational loop.

Parameters:
- ACCESS_CYCLES, 3: SRAM cycles per access. Legal range is ≥3.
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: data word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- hold  in  1  pipeline stall from stall logic; 0 at an edge means the pipeline advances.
- if_addr  in  ADDR_W  instruction fetch address; stable while hold=1.
- inst  out  DATA_W  fetched instruction word; valid while inst_read_done=1.
- inst_read_done  out  1  registered; instruction for current if_addr is available.
- mem_op  in  1  MEM stage requests a data access.
- mem_we  in  1  1=write, 0=read; qualified by mem_op.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid while mem_done=1 after a read.
- mem_done  out  1  registered; current data access is complete.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_data_oe  out  1  1 drives the SRAM data bus (tristate enable at top level).
- sram_rdata  in  DATA_W  SRAM data bus input.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
Reset values (rst=1 at an edge):
- State IDLE, counter 0.
- inst_read_done=0, mem_done=0, inst=0, mem_rdata=0.
- sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_data_oe=0, sram_addr=0, sram_wdata=0.
- Reset mid-access aborts immediately. There is no partial write beyond the cycle reset arrives.

States: IDLE, DATA, INST.

IDLE:
- If hold=0 this edge: clear both done flags and stay IDLE. New requests are evaluated next cycle.
- Else if mem_op=1 and mem_done=0: go to DATA. Data has priority (older instruction).
- Else if inst_read_done=0: go to INST.
- Else: stay IDLE with SRAM idle (ce_n=oe_n=we_n=1).

DATA and INST:
- Each lasts exactly ACCESS_CYCLES cycles, counted 0..ACCESS_CYCLES-1.
- sram_addr and sram_wdata are registered on entry and held for the whole access.
- sram_ce_n=0 throughout.
- Read (INST, or DATA with mem_we=0):
  - sram_oe_n=0, we_n=1, data_oe=0.
  - sram_rdata is sampled at the edge ending the last cycle into inst or mem_rdata.
- Write (DATA, mem_we=1):
  - oe_n=1, data_oe=1 in all cycles.
  - sram_we_n=0 in cycles 1..ACCESS_CYCLES-2; high in cycle 0 (address setup) and in the last cycle (hold).
- At the edge ending the last cycle:
  - Set mem_done=1 (DATA) or inst_read_done=1 (INST).
  - Return to IDLE; the SRAM goes idle the next cycle.

Done flags:
- Sticky: they stay 1 until an edge with hold=0, then clear to 0. Data outputs keep their last value.
- Writes set mem_done; mem_rdata is unchanged.
- hold=0 seen during DATA/INST is a protocol error; the FSM ignores it and completes the access.

Latency:
- Fetch-only cycle, counted from the advance edge to inst_read_done=1: ACCESS_CYCLES+1 edges.
- Fetch plus data cycle: 2·(ACCESS_CYCLES+1) edges, data first, then instruction.

Bus rules:
- sram_data_oe must never be 1 while sram_oe_n=0.
- When mem_op=0, mem_done is not required for the pipeline to advance and stays 0.

Test Plan:
- Reset, then release with hold tied to the model's stall equation, if_addr=0x00010, SRAM[0x10]=0x1234:
  - expect INST access sram_addr=0x10 and oe_n low for 3 cycles;
  - expect inst_read_done=1 and inst=0x1234 on the 4th edge after release.
- mem_op=1, mem_we=0, mem_addr=0x00200 (=0xBEEF), with a fetch also pending:
  - expect the DATA access first, then mem_done=1 and mem_rdata=0xBEEF;
  - expect the INST access next, with inst_read_done 4 edges after mem_done;
  - expect hold to fall only after both flags are set.
- Write mem_addr=0x00300, mem_wdata=0xA5A5:
  - expect we_n low exactly in cycle 1 and data_oe=1 for 3 cycles;
  - a later read of 0x300 returns 0xA5A5.
- Done flags stay 1 while hold=1 is forced externally for 5 cycles; both clear on the edge with hold=0; the next access starts one cycle later.
- rst=1 asserted in cycle 1 of a write:
  - next cycle we_n=1, ce_n=1, data_oe=0, state IDLE;
  - flags 0 and memory content unchanged at 0x300 if the model's write strobe never completed.
- ACCESS_CYCLES=5: write we_n low in cycles 1–3; fetch latency 6 edges.
